// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg: shared constants for the instruction memory controller.
// Holds the loader FSM state encoding and default geometry.
// Optional feature macro used by the RTL: IMEM_PARITY_EN (stored even parity).
package instr_mem_pkg;

  // Default geometry: word-addressed, one instruction per word.
  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 32;
  localparam int IMEM_DEPTH  = 256;

  // Loader FSM encoding; kept as plain constants so it maps onto legacy code.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Extra stored bit per word when the parity option is compiled in.
`ifdef IMEM_PARITY_EN
  localparam int IMEM_PAR_W = 1;
`else
  localparam int IMEM_PAR_W = 0;
`endif

endpackage

// File: rtl/instr_mem_array.sv
// instr_mem_array: storage only. One synchronous write port and one
// synchronous read port. Contents are deliberately never reset so that a
// reset during a program load keeps the words already written.
// Width is chosen by the parent (data, plus a parity bit when IMEM_PARITY_EN).
module instr_mem_array
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WIDTH  = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Write port: the parent only enables it for in-range addresses.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read port: output register only updates on an enabled read, so the last
  // fetched word is held while no read is issued.
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: instruction memory with a registered fetch port (latency 1,
// one result per cycle, no back-pressure) and a streaming program loader.
//
// Loader handshake: a beat transfers on any rising edge where
// ld_valid && ld_ready; ld_ready is high exactly while the FSM is in LOAD.
// The load ends on a beat carrying ld_last, or on the beat that fills the
// last implemented word (which also raises the sticky ld_ovf).
//
// Fetches are faulted (rd_err=1, rd_data=0) when the address is beyond the
// implemented depth or the loader is busy (LOAD or DONE), which also rules out
// a same-address read/write collision.
//
// Optional feature: define IMEM_PARITY_EN to store an even-parity bit per
// word and flag a fetch fault on parity mismatch.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch port
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  // loader port
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_ovf,
  output logic [ADDR_W:0]   ld_count,
  // loader FSM state, exposed for debug and checkers
  output logic [1:0]        dbg_state
);

  localparam int WORD_W = DATA_W + IMEM_PAR_W;

  // Depth limits in a width one bit wider than the address so that
  // DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_LAST  = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic              r_rd_valid;
  logic              r_rd_ok;

  logic              w_beat;
  logic              w_ptr_last;
  logic              w_base_bad;
  logic              w_rd_fault;
  logic              w_rd_en;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_arr_q;
  logic              w_par_bad;

  assign w_beat     = ld_valid && (r_state == ST_LOAD);
  assign w_ptr_last = ({1'b0, r_ptr} == LP_LAST);
  assign w_base_bad = ({1'b0, ld_base} >= LP_DEPTH);
  assign w_rd_fault = ({1'b0, rd_addr} >= LP_DEPTH) || (r_state != ST_IDLE);
  assign w_rd_en    = rd_req && !w_rd_fault;

`ifdef IMEM_PARITY_EN
  // Even parity: stored bit makes the XOR of the whole word zero.
  assign w_wr_word = {^ld_data, ld_data};
  assign w_par_bad = r_rd_ok && (^w_arr_q);
`else
  assign w_wr_word = ld_data;
  assign w_par_bad = 1'b0;
`endif

  // Loader FSM, write pointer, beat counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ld_start) begin
            r_ptr   <= ld_base;
            r_count <= '0;
            // A base past the implemented depth cannot write anything.
            r_ovf   <= w_base_bad;
            r_state <= w_base_bad ? ST_DONE : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_count <= r_count + 1'b1;
            // Pointer never wraps; the load ends at the last word anyway.
            if (!w_ptr_last) begin
              r_ptr <= r_ptr + 1'b1;
            end
            if (ld_last || w_ptr_last) begin
              r_ovf   <= w_ptr_last && !ld_last;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Fetch status: valid follows the request by one cycle; the ok flag only
  // changes on a request so the presented data holds between fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_ok <= !w_rd_fault;
      end
    end
  end

  instr_mem_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk       (clk),
    .i_wr_en   (w_beat),
    .i_wr_addr (r_ptr),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (w_arr_q)
  );

  assign rd_valid  = r_rd_valid;
  assign rd_err    = r_rd_valid && (!r_rd_ok || w_par_bad);
  assign rd_data   = (r_rd_ok && !w_par_bad) ? w_arr_q[DATA_W-1:0] : '0;
  assign ld_ready  = (r_state == ST_LOAD);
  assign ld_done   = (r_state == ST_DONE);
  assign ld_ovf    = r_ovf;
  assign ld_count  = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed bench for instr_mem_ctrl (DEPTH=200).
// Reads push {err,data} into exp_q when issued; a negedge monitor pops and
// compares whenever rd_valid is high. Loader status is checked inline.
// Honors IMEM_PARITY_EN for the corrupted-word case.
module tb_instr_mem_ctrl;
  import instr_mem_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 200;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rd_req   = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base  = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data  = '0;
  logic          ld_last  = 1'b0;
  logic          ld_ready;
  logic          ld_done;
  logic          ld_ovf;
  logic [AW:0]   ld_count;
  logic [1:0]    dbg_state;

  instr_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ld_done(ld_done), .ld_ovf(ld_ovf), .ld_count(ld_count),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: one expected entry per presented fetch result.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rd_unexpected: rd_valid=1 data 0x%0h, expected no result (t=%0t)", rd_data, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rd_err", {63'd0, rd_err}, {63'd0, mon_e[DW]});
        check("rd_data", {32'd0, rd_data}, {32'd0, mon_e[DW-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to the next negedge and return inputs to their idle values.
  task automatic cyc();
    @(negedge clk);
    rd_req   = 1'b0;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] addr, input logic err, input logic [DW-1:0] data);
    rd_req  = 1'b1;
    rd_addr = addr;
    exp_q.push_back({err, data});
  endtask

  task automatic beat(input logic [DW-1:0] data, input logic last);
    ld_valid = 1'b1;
    ld_data  = data;
    ld_last  = last;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_rd_err", {63'd0, rd_err}, 64'd0);
    check("rst_rd_data", {32'd0, rd_data}, 64'd0);
    check("rst_ld_ready", {63'd0, ld_ready}, 64'd0);
    check("rst_ld_done", {63'd0, ld_done}, 64'd0);
    check("rst_ld_ovf", {63'd0, ld_ovf}, 64'd0);
    check("rst_ld_count", {55'd0, ld_count}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;

    // Load 4 beats at base 10
    cyc(); ld_start = 1'b1; ld_base = 8'd10;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("load_ready", {63'd0, ld_ready}, 64'd1);
      beat(32'hA0 + i, i == 3);
    end
    cyc();
    check("load_done", {63'd0, ld_done}, 64'd1);
    check("load_count", {55'd0, ld_count}, 64'd4);
    check("load_ovf", {63'd0, ld_ovf}, 64'd0);
    check("load_ready_off", {63'd0, ld_ready}, 64'd0);
    cyc();
    check("load_done_pulse", {63'd0, ld_done}, 64'd0);
    check("load_state_idle", {62'd0, dbg_state}, 64'd0);

    // Read back 10..13, then back-to-back 10,11,12
    for (int i = 0; i < 4; i++) begin
      cyc(); issue_read(8'(10 + i), 1'b0, 32'hA0 + i);
    end
    cyc(); issue_read(8'd10, 1'b0, 32'hA0);
    cyc(); check("b2b_valid0", {63'd0, rd_valid}, 64'd1); issue_read(8'd11, 1'b0, 32'hA1);
    cyc(); check("b2b_valid1", {63'd0, rd_valid}, 64'd1); issue_read(8'd12, 1'b0, 32'hA2);
    cyc(); check("b2b_valid2", {63'd0, rd_valid}, 64'd1);
    cyc();
    check("idle_valid", {63'd0, rd_valid}, 64'd0);
    check("idle_hold", {32'd0, rd_data}, 64'hA2);

    // Out-of-range fetches
    cyc(); issue_read(8'd250, 1'b1, 32'd0);
    cyc(); issue_read(8'd200, 1'b1, 32'd0);
    cyc();

    // Base beyond depth: straight to DONE with overflow
    cyc(); ld_start = 1'b1; ld_base = 8'd220;
    cyc();
    check("badbase_done", {63'd0, ld_done}, 64'd1);
    check("badbase_ovf", {63'd0, ld_ovf}, 64'd1);
    check("badbase_count", {55'd0, ld_count}, 64'd0);
    check("badbase_ready", {63'd0, ld_ready}, 64'd0);

    // Overflow load at DEPTH-2, three beats, no last
    cyc(); cyc(); ld_start = 1'b1; ld_base = 8'(DEPTH - 2);
    cyc();
    check("ovf_ready0", {63'd0, ld_ready}, 64'd1);
    check("ovf_cleared", {63'd0, ld_ovf}, 64'd0);
    beat(32'h5EED0000, 1'b0);
    cyc(); beat(32'h5EED0001, 1'b0);
    cyc();
    check("ovf_ready_off", {63'd0, ld_ready}, 64'd0);
    check("ovf_done", {63'd0, ld_done}, 64'd1);
    check("ovf_flag", {63'd0, ld_ovf}, 64'd1);
    check("ovf_count", {55'd0, ld_count}, 64'd2);
    beat(32'h5EED0002, 1'b0);
    ld_start = 1'b1; ld_base = 8'd5;   // ignored outside IDLE
    cyc();
    check("ovf_start_ignored", {62'd0, dbg_state}, 64'd0);
    check("ovf_flag_kept", {63'd0, ld_ovf}, 64'd1);
    check("ovf_count_kept", {55'd0, ld_count}, 64'd2);
    cyc(); issue_read(8'(DEPTH - 2), 1'b0, 32'h5EED0000);
    cyc(); issue_read(8'(DEPTH - 1), 1'b0, 32'h5EED0001);

    // Fetch during load, then reset after two beats
    cyc(); ld_start = 1'b1; ld_base = 8'd40;
    cyc(); beat(32'hB0, 1'b0); issue_read(8'd10, 1'b1, 32'd0);
    cyc(); beat(32'hB1, 1'b0);
    check("midload_count", {55'd0, ld_count}, 64'd1);
    cyc();
    check("midload_count2", {55'd0, ld_count}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("abort_state", {62'd0, dbg_state}, 64'd0);
    check("abort_ready", {63'd0, ld_ready}, 64'd0);
    check("abort_count", {55'd0, ld_count}, 64'd0);
    check("abort_valid", {63'd0, rd_valid}, 64'd0);
    check("abort_rd_data", {32'd0, rd_data}, 64'd0);
    check("abort_done_ovf", {62'd0, ld_done, ld_ovf}, 64'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    issue_read(8'd40, 1'b0, 32'hB0);
    cyc(); issue_read(8'd41, 1'b0, 32'hB1);
    cyc(); issue_read(8'd10, 1'b0, 32'hA0);

    // Corrupt one stored data bit of word 11 (holds 0xA1)
    cyc();
    dut.u_array.r_mem[11][0] <= ~dut.u_array.r_mem[11][0];
    cyc();
`ifdef IMEM_PARITY_EN
    issue_read(8'd11, 1'b1, 32'd0);
`else
    issue_read(8'd11, 1'b0, 32'hA0);
`endif
    cyc();

    // Drain outstanding results
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("rd_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
